// File: rtl/fft_frame_ctrl_if.sv
// Handshake/strobe bundle between the FFT frame sequencer (master) and the
// S/P buffer, butterfly datapath and P/S buffer it steers (slave).
interface fft_frame_ctrl_if;
  logic       start;
  logic       clr_err;
  logic       in_valid;
  logic       in_ready;
  logic       s_p_we;
  logic [3:0] s_p_idx;
  logic       bf_en;
  logic       bf_stage;
  logic [1:0] bf_grp;
  logic       p_s_flag_in;
  logic [1:0] p_s_sel;
  logic       out_valid;
  logic [3:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       frame_done;
  logic       err_start;

  modport master (
    input  start, clr_err, in_valid,
    output in_ready, s_p_we, s_p_idx, bf_en, bf_stage, bf_grp,
           p_s_flag_in, p_s_sel, out_valid, out_idx, out_last,
           busy, frame_done, err_start
  );

  modport slave (
    output start, clr_err, in_valid,
    input  in_ready, s_p_we, s_p_idx, bf_en, bf_stage, bf_grp,
           p_s_flag_in, p_s_sel, out_valid, out_idx, out_last,
           busy, frame_done, err_start
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT: LOAD -> COMP -> WAIT -> UNLD -> SER.
// Define FFT_CTRL_CONT_EN for continuous mode (SER exit re-enters LOAD without a new start).
module fft_frame_ctrl #(
  parameter int N_POINT  = 16,
  parameter int LANES    = 4,
  parameter int NUM_STG  = 2,
  parameter int PIPE_LAT = 3
) (
  input logic              clk,
  input logic              rst_n,
  fft_frame_ctrl_if.master bus
);

  localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [3:0]        S_LAST = 4'(N_POINT - 1);
  localparam logic [2:0]        C_LAST = 3'(NUM_STG * LANES - 1);
  localparam logic [1:0]        G_LAST = 2'(LANES - 1);
  localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMP,
    WAIT,
    UNLD,
    SER
  } state_t;

  state_t              state;
  logic                in_ready_q;
  logic [3:0]          s_p_idx_q;
  logic                bf_en_q;
  logic [2:0]          comp_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                ps_flag_q;
  logic [1:0]          ps_sel_q;
  logic                out_valid_q;
  logic [3:0]          out_idx_q;
  logic                out_last_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                err_q;
  logic                accept;

  assign accept = bus.in_valid & in_ready_q;

  assign bus.in_ready    = in_ready_q;
  assign bus.s_p_we      = accept;
  assign bus.s_p_idx     = s_p_idx_q;
  assign bus.bf_en       = bf_en_q;
  assign bus.bf_stage    = comp_cnt_q[2];
  assign bus.bf_grp      = comp_cnt_q[1:0];
  assign bus.p_s_flag_in = ps_flag_q;
  assign bus.p_s_sel     = ps_sel_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_start   = err_q;

  // Every counter is returned to 0 on the edge that leaves its state, so
  // counters read 0 whenever their strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready_q   <= 1'b0;
      s_p_idx_q    <= '0;
      bf_en_q      <= 1'b0;
      comp_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      ps_flag_q    <= 1'b0;
      ps_sel_q     <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // A start seen mid-frame is a protocol error; setting beats clearing.
      if (bus.start && (state != IDLE)) begin
        err_q <= 1'b1;
      end else if (bus.clr_err) begin
        err_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            if (s_p_idx_q == S_LAST) begin
              s_p_idx_q  <= '0;
              in_ready_q <= 1'b0;
              bf_en_q    <= 1'b1;
              comp_cnt_q <= '0;
              state      <= COMP;
            end else begin
              s_p_idx_q <= s_p_idx_q + 4'd1;
            end
          end
        end

        COMP: begin
          if (comp_cnt_q == C_LAST) begin
            comp_cnt_q <= '0;
            bf_en_q    <= 1'b0;
            if (PIPE_LAT == 0) begin
              ps_flag_q <= 1'b1;
              ps_sel_q  <= '0;
              state     <= UNLD;
            end else begin
              wait_cnt_q <= '0;
              state      <= WAIT;
            end
          end else begin
            comp_cnt_q <= comp_cnt_q + 3'd1;
          end
        end

        WAIT: begin
          if (wait_cnt_q == W_LAST) begin
            wait_cnt_q <= '0;
            ps_flag_q  <= 1'b1;
            ps_sel_q   <= '0;
            state      <= UNLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        UNLD: begin
          if (ps_sel_q == G_LAST) begin
            ps_sel_q    <= '0;
            ps_flag_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            state       <= SER;
          end else begin
            ps_sel_q <= ps_sel_q + 2'd1;
          end
        end

        SER: begin
          if (out_idx_q == S_LAST) begin
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b1;
`ifdef FFT_CTRL_CONT_EN
            in_ready_q   <= 1'b1;
            state        <= LOAD;
`else
            busy_q       <= 1'b0;
            state        <= IDLE;
`endif
          end else begin
            out_idx_q  <= out_idx_q + 4'd1;
            out_last_q <= (out_idx_q == S_LAST - 4'd1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
